downsample2x_stream: RTL and testbench

Streaming 2x2/stride-2 spatial downsampler for the YOLO feature-map datapath: the inverse of the nearest-neighbour 2x upsample stage. It accepts one channel of an H x W feature map in raster order over a valid/ready stream. For every 2x2 input window it emits one reduced pixel (max by default, average when configured), giving an (H/2) x (W/2) output map. A W/2-entry line buffer holds the partial results of the even row, so no full frame is ever buffered.

---
 rtl/downsample2x_stream_if.sv | 22 ++
 rtl/downsample2x_stream.sv | 129 ++++++++++++
 tb/tb_downsample2x_stream.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/downsample2x_stream_if.sv
// rtl/downsample2x_stream_if.sv - Input/output pixel stream bundle for downsample2x_stream.
interface downsample2x_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/downsample2x_stream.sv
// rtl/downsample2x_stream.sv - Streaming 2x2/stride-2 downsampler (max; 2x2 average with DOWNSAMPLE2X_AVG_EN).
// The even row's pair results live in a half-width line buffer; the odd row completes each window.
module downsample2x_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int W          = 4,
    parameter int H          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    downsample2x_stream_if.slave  strm
);
    localparam int CW       = $clog2(W);
    localparam int RW       = $clog2(H);
    localparam int LB_AW    = (W > 2) ? $clog2(W / 2) : 1;
    localparam int LB_DEPTH = 1 << LB_AW;
`ifdef DOWNSAMPLE2X_AVG_EN
    localparam int LBW      = DATA_WIDTH + 1;
`else
    localparam int LBW      = DATA_WIDTH;
`endif

    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic signed [LBW-1:0]        linebuf [LB_DEPTH];

    logic                         in_fire, col_last, row_last, lb_we, win_fire;
    logic [LB_AW-1:0]             lb_idx;
    logic signed [LBW-1:0]        lb_rd;
    logic signed [LBW-1:0]        pair_red;
    logic signed [DATA_WIDTH-1:0] win_result;

    assign strm.in_ready  = !out_valid_q || strm.out_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_last  = out_last_q;

    assign in_fire  = strm.in_valid && strm.in_ready;
    assign col_last = (col_q == CW'(W - 1));
    assign row_last = (row_q == RW'(H - 1));
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign lb_we    = in_fire && !row_q[0] && col_q[0];
    assign win_fire = in_fire && row_q[0] && col_q[0];

`ifdef DOWNSAMPLE2X_AVG_EN
    logic signed [DATA_WIDTH+1:0] sum4, sum4_shr;

    assign pair_red   = {pair_q[DATA_WIDTH-1], pair_q} + {strm.in_data[DATA_WIDTH-1], strm.in_data};
    assign sum4       = {{2{pair_q[DATA_WIDTH-1]}}, pair_q}
                      + {{2{strm.in_data[DATA_WIDTH-1]}}, strm.in_data}
                      + {lb_rd[LBW-1], lb_rd};
    // Arithmetic shift floors toward -inf; the quotient of four in-range values always fits.
    assign sum4_shr   = sum4 >>> 2;
    assign win_result = sum4_shr[DATA_WIDTH-1:0];
`else
    function automatic logic signed [DATA_WIDTH-1:0] max2(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    assign pair_red   = max2(pair_q, strm.in_data);
    assign win_result = max2(max2(pair_q, strm.in_data), lb_rd);
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_fire) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        pair_d = pair_q;
        if (in_fire && !col_q[0]) begin
            pair_d = strm.in_data;
        end
    end

    // A completing window in the same cycle as an output transfer keeps out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_valid_q && strm.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (win_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = win_result;
            out_last_d  = row_last && col_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= pair_red;
        end
    end
endmodule

// File: tb/tb_downsample2x_stream.sv
// tb/tb_downsample2x_stream.sv - Directed self-checking bench for downsample2x_stream (max, or average with DOWNSAMPLE2X_AVG_EN).
module tb_downsample2x_stream;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    downsample2x_stream_if #(.DATA_WIDTH(DW)) bus ();

    downsample2x_stream #(.DATA_WIDTH(DW), .W(4), .H(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int in_count = 0;
    int out_q[$];
    int last_q[$];
    int lat_q[$];
    int exp_q[$];
    int exp_last_q[$];

    int sgn_frame[16] = '{-3, -1, -32768, -32768,
                          -8, -2, -32768, -32768,
                          100, -100, -1, -2,
                          -200, 50, -1, -2};
`ifdef DOWNSAMPLE2X_AVG_EN
    int ramp_exp[4] = '{2, 4, 10, 12};
    int sgn_exp[4]  = '{-4, -32768, -38, -2};
`else
    int ramp_exp[4] = '{5, 7, 13, 15};
    int sgn_exp[4]  = '{-1, -32768, 100, -1};
`endif
    int ramp_lat[4] = '{6, 8, 14, 16};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(int'(bus.out_data));
                last_q.push_back(int'(bus.out_last));
                lat_q.push_back(in_count);
            end
            if (bus.in_valid && bus.in_ready) begin
                in_count++;
            end
        end
    end

    task automatic clear();
        out_q.delete();
        last_q.delete();
        lat_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        in_count = 0;
    endtask

    task automatic send(input int v);
        bit done;
        done = 1'b0;
        bus.in_data  = 16'(v);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input int kind);
        for (int i = 0; i < 16; i++) begin
            send(kind == 0 ? i : sgn_frame[i]);
        end
    endtask

    task automatic expect_frame(input int kind);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(kind == 0 ? ramp_exp[i] : sgn_exp[i]);
            exp_last_q.push_back(i == 3 ? 1 : 0);
        end
    endtask

    task automatic drain_and_verify(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), out_q[i], exp_q[i]);
                check($sformatf("%s_last%0d", tag, i), last_q[i], exp_last_q[i]);
            end
        end
    endtask

    task automatic stall_checker();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
        end
        check("bp_first_output_seen", int'(found), 1);
        if (found) begin
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                check($sformatf("bp_in_ready%0d", k), int'(bus.in_ready), 0);
                check($sformatf("bp_hold%0d", k), int'(bus.out_data), ramp_exp[0]);
                check($sformatf("bp_in_count%0d", k), in_count, 6);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp frame with per-output latency
        clear();
        send_frame(0);
        expect_frame(0);
        drain_and_verify("ramp");
        for (int i = 0; i < 4; i++) begin
            if (i < lat_q.size()) check($sformatf("ramp_lat%0d", i), lat_q[i], ramp_lat[i]);
        end
        check("ramp_idle_valid", int'(bus.out_valid), 0);

        // Signed windows including the most negative value
        clear();
        send_frame(1);
        expect_frame(1);
        drain_and_verify("signed");

        // Backpressure: first output stalls for 5 cycles
        clear();
        bus.out_ready = 1'b0;
        fork
            send_frame(0);
            stall_checker();
        join
        expect_frame(0);
        drain_and_verify("bp");

        // Two frames back to back
        clear();
        send_frame(1);
        send_frame(0);
        expect_frame(1);
        expect_frame(0);
        drain_and_verify("b2b");

        // Reset mid-frame with a pending stalled output
        clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i);
        check("pre_rst_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(bus.out_valid), 0);
        check("async_rst_data", int'(bus.out_data), 0);
        check("async_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        bus.out_ready = 1'b1;
        send_frame(0);
        expect_frame(0);
        drain_and_verify("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
